// File: rtl/ahb_pkg.sv
// ============================================================================
// Module   : ahb_pkg
// Brief    : Shared handler command encodings and sequencer FSM state codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

    // One-hot commands decoded by the AHB write/read handler
    localparam logic [5:0] IDLE    = 6'b000001;
    localparam logic [5:0] SBURSTW = 6'b000010;
    localparam logic [5:0] SBURSTR = 6'b000100;
    localparam logic [5:0] INCRBW  = 6'b001000;
    localparam logic [5:0] INCRBR  = 6'b010000;
    localparam logic [5:0] BUSY    = 6'b100000;

    localparam int         SEQ_STATE_W = 2;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_XFER      = 2'd1;
    localparam logic [1:0] S_PAUSE     = 2'd2;

    function automatic logic [5:0] burst_cmd(input logic wr, input logic multi);
        if (multi) burst_cmd = wr ? INCRBW : INCRBR;
        else       burst_cmd = wr ? SBURSTW : SBURSTR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-input round-robin arbiter; last-granted input loses ties.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic [1:0] upd_gnt,
    output logic [1:0] gnt
);

    // Reset to "requester 1 granted last" so requester 0 wins the first tie
    logic r_last;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)  r_last <= 1'b1;
        else if (upd)  r_last <= upd_gnt[1];
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ahb_master_sequencer.sv
// ============================================================================
// Module   : ahb_master_sequencer
// Brief    : Arbitrates two requesters into a one-hot AHB handler command
//            stream. Define AHB_SEQ_BUSY_INS_EN to enable BUSY insertion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_master_sequencer
    import ahb_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [1:0]       REQ,
    input  logic [1:0]       RWRITE,
    input  logic [LEN_W-1:0] RLEN0,
    input  logic [LEN_W-1:0] RLEN1,
    input  logic [25:0]      RADDR0,
    input  logic [25:0]      RADDR1,
    input  logic [31:0]      RDATA0,
    input  logic [31:0]      RDATA1,
    input  logic [1:0]       RVALID,
    input  logic             WAIT,
    output logic [1:0]       GNT,
    output logic [1:0]       ACK,
    output logic [1:0]       FIN,
    output logic [5:0]       state,
    output logic [25:0]      ADDR,
    output logic [31:0]      DATA
);

    logic [SEQ_STATE_W-1:0] r_fsm;
    logic [1:0]             r_gnt;
    logic                   r_wr;
    logic [LEN_W-1:0]       r_cnt;
    logic [25:0]            r_addr;
    logic [5:0]             r_state;

    logic [1:0]             w_arb_gnt;
    logic                   w_win_wr;
    logic [LEN_W-1:0]       w_win_len;
    logic [25:0]            w_win_addr;
    logic                   w_vld;
    logic                   w_accept;
    logic                   w_last;

    rr_arbiter2 u_arb (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .req     (REQ),
        .upd     (|FIN),
        .upd_gnt (r_gnt),
        .gnt     (w_arb_gnt)
    );

    assign w_win_wr   = w_arb_gnt[1] ? RWRITE[1] : RWRITE[0];
    assign w_win_len  = w_arb_gnt[1] ? RLEN1     : RLEN0;
    assign w_win_addr = w_arb_gnt[1] ? RADDR1    : RADDR0;

`ifdef AHB_SEQ_BUSY_INS_EN
    logic r_multi;
    assign w_vld = |(RVALID & r_gnt);
`else
    // Requesters guarantee valid write data every cycle, so RVALID is not used
    logic w_unused_rvalid;
    assign w_unused_rvalid = ^RVALID;
    assign w_vld           = 1'b1;
`endif

    assign w_accept = (r_fsm == S_XFER) && !WAIT && (!r_wr || w_vld);
    assign w_last   = (r_cnt == '0);

    assign ACK   = w_accept ? r_gnt : 2'b00;
    assign FIN   = (w_accept && w_last) ? r_gnt : 2'b00;
    assign GNT   = r_gnt;
    assign state = r_state;
    assign ADDR  = r_addr;
    assign DATA  = !r_wr     ? 32'd0  :
                   r_gnt[1]  ? RDATA1 :
                   r_gnt[0]  ? RDATA0 : 32'd0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_fsm   <= S_IDLE;
            r_gnt   <= 2'b00;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= 26'd0;
            r_state <= IDLE;
`ifdef AHB_SEQ_BUSY_INS_EN
            r_multi <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (|REQ) begin
                        r_gnt   <= w_arb_gnt;
                        r_wr    <= w_win_wr;
                        r_cnt   <= w_win_len;
                        r_addr  <= w_win_addr;
                        r_state <= burst_cmd(w_win_wr, |w_win_len);
                        r_fsm   <= S_XFER;
`ifdef AHB_SEQ_BUSY_INS_EN
                        r_multi <= |w_win_len;
`endif
                    end
                end
                S_XFER: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_fsm   <= S_IDLE;
                            r_gnt   <= 2'b00;
                            r_wr    <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
`ifdef AHB_SEQ_BUSY_INS_EN
                    // Not accepted without WAIT means a write starved of data
                    else if (r_wr && !WAIT) begin
                        r_fsm   <= S_PAUSE;
                        r_state <= BUSY;
                    end
`endif
                end
`ifdef AHB_SEQ_BUSY_INS_EN
                S_PAUSE: begin
                    if (w_vld) begin
                        r_fsm   <= S_XFER;
                        r_state <= burst_cmd(1'b1, r_multi);
                    end
                end
`endif
                default: begin
                    r_fsm   <= S_IDLE;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_master_sequencer.sv
// ============================================================================
// Module   : tb_ahb_master_sequencer
// Brief    : Self-checking bench: burst table, directed corner cases and
//            random traffic against a beat-counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ahb_master_sequencer;
    import ahb_pkg::*;

    localparam int LEN_W = 4;
`ifdef AHB_SEQ_BUSY_INS_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic [1:0]       REQ = '0, RWRITE = '0, RVALID = '0;
    logic [LEN_W-1:0] RLEN0 = '0, RLEN1 = '0;
    logic [25:0]      RADDR0 = '0, RADDR1 = '0;
    logic [31:0]      RDATA0 = '0, RDATA1 = '0;
    logic             WAIT = 1'b0;
    logic [1:0]       GNT, ACK, FIN;
    logic [5:0]       state;
    logic [25:0]      ADDR;
    logic [31:0]      DATA;

    ahb_master_sequencer #(.LEN_W(LEN_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .REQ(REQ), .RWRITE(RWRITE),
        .RLEN0(RLEN0), .RLEN1(RLEN1), .RADDR0(RADDR0), .RADDR1(RADDR1),
        .RDATA0(RDATA0), .RDATA1(RDATA1), .RVALID(RVALID), .WAIT(WAIT),
        .GNT(GNT), .ACK(ACK), .FIN(FIN), .state(state), .ADDR(ADDR), .DATA(DATA)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: burst owner plus remaining beat count
    bit          m_act, m_pause, m_wr, m_multi;
    int          m_own, m_left, m_last;
    logic [25:0] m_addr;
    logic [5:0]  obs_state;
    logic [1:0]  obs_ack, obs_fin, obs_gnt;
    logic [31:0] obs_data;

    function automatic logic [5:0] exp_cmd(input bit wr, input bit multi);
        return multi ? (wr ? INCRBW : INCRBR) : (wr ? SBURSTW : SBURSTR);
    endfunction

    task automatic model_reset();
        m_act = 0; m_pause = 0; m_wr = 0; m_multi = 0;
        m_own = 0; m_left = 0; m_last = 1; m_addr = '0;
    endtask

    task automatic step();
        logic [5:0]  es;
        logic [1:0]  eg, ea, ef;
        logic [31:0] ed;
        bit          vld, acc;
        #1;
        es  = !m_act ? IDLE : (m_pause ? BUSY : exp_cmd(m_wr, m_multi));
        eg  = m_act ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00;
        vld = !m_wr || !BUSY_EN || RVALID[m_own];
        acc = m_act && !m_pause && !WAIT && vld;
        ea  = acc ? eg : 2'b00;
        ef  = (acc && m_left == 1) ? eg : 2'b00;
        ed  = (m_act && m_wr) ? ((m_own == 1) ? RDATA1 : RDATA0) : 32'd0;
        obs_state = state; obs_ack = ACK; obs_fin = FIN; obs_gnt = GNT; obs_data = DATA;
        chk("state", 64'(state), 64'(es));
        chk("GNT",   64'(GNT),   64'(eg));
        chk("ACK",   64'(ACK),   64'(ea));
        chk("FIN",   64'(FIN),   64'(ef));
        chk("ADDR",  64'(ADDR),  64'(m_addr));
        chk("DATA",  64'(DATA),  64'(ed));
        if (!m_act) begin
            if (REQ != 2'b00) begin
                int p;
                logic [LEN_W-1:0] ln;
                p       = (REQ == 2'b11) ? ((m_last == 0) ? 1 : 0) : (REQ[1] ? 1 : 0);
                ln      = (p == 1) ? RLEN1 : RLEN0;
                m_act   = 1;
                m_pause = 0;
                m_own   = p;
                m_wr    = RWRITE[p];
                m_left  = int'(ln) + 1;
                m_multi = (ln != 0);
                m_addr  = (p == 1) ? RADDR1 : RADDR0;
            end
        end else if (m_pause) begin
            if (RVALID[m_own]) m_pause = 0;
        end else if (acc) begin
            m_left--;
            if (m_left == 0) begin
                m_act  = 0;
                m_last = m_own;
            end
        end else if (BUSY_EN && m_wr && !WAIT) begin
            m_pause = 1;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        #1;
        chk("rst_state", 64'(state), 64'(IDLE));
        chk("rst_GNT",   64'(GNT),   64'd0);
        chk("rst_ACK",   64'(ACK),   64'd0);
        chk("rst_FIN",   64'(FIN),   64'd0);
        chk("rst_ADDR",  64'(ADDR),  64'd0);
        chk("rst_DATA",  64'(DATA),  64'd0);
        model_reset();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    typedef struct {
        int               who;
        bit               wr;
        logic [LEN_W-1:0] len;
        logic [25:0]      addr;
        logic [5:0]       cmd;
        int               cycles;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, acks, fins, cnt_cmd, cnt_busy;
        bit done;
        logic [31:0] held;
        logic [1:0] arb_exp [9];

        vecs[0] = '{0, 1'b1, 4'd0,  26'd500,    SBURSTW, 1};
        vecs[1] = '{0, 1'b1, 4'd3,  26'h12345,  INCRBW,  4};
        vecs[2] = '{1, 1'b0, 4'd0,  26'h3ffffff, SBURSTR, 1};
        vecs[3] = '{1, 1'b0, 4'd15, 26'h0abcde, INCRBR,  16};
        vecs[4] = '{0, 1'b0, 4'd2,  26'd7,      INCRBR,  3};
        vecs[5] = '{1, 1'b1, 4'd1,  26'h2000000, INCRBW, 2};

        model_reset();
        @(posedge HCLK);
        #1;
        do_reset();

        // Table of single bursts; REQ drops after the grant and must be ignored
        for (int v = 0; v < 6; v++) begin
            REQ = (vecs[v].who == 1) ? 2'b10 : 2'b01;
            RWRITE = vecs[v].wr ? 2'b11 : 2'b00;
            RLEN0 = vecs[v].len; RLEN1 = vecs[v].len;
            RADDR0 = vecs[v].addr; RADDR1 = vecs[v].addr;
            RVALID = 2'b11; WAIT = 1'b0;
            step();
            REQ = 2'b00;
            cyc = 0; acks = 0; done = 0;
            for (int k = 0; k < 40 && !done; k++) begin
                RDATA0 = $urandom; RDATA1 = $urandom;
                step();
                cyc++;
                chk("vec_cmd", 64'(obs_state), 64'(vecs[v].cmd));
                if (obs_ack != 2'b00) acks++;
                if (obs_fin != 2'b00) done = 1;
            end
            chk("vec_fin_seen", 64'(done), 64'd1);
            chk("vec_cycles", 64'(cyc), 64'(vecs[v].cycles));
            chk("vec_acks", 64'(acks), 64'(int'(vecs[v].len) + 1));
            step();
            chk("vec_turnaround_idle", 64'(obs_state), 64'(IDLE));
        end

        // WAIT on beat 2 of a 4-beat write stretches INCRBW to 5 cycles
        REQ = 2'b01; RWRITE = 2'b01; RLEN0 = 4'd3; RADDR0 = 26'h111; RVALID = 2'b11;
        step();
        REQ = 2'b00;
        cnt_cmd = 0; acks = 0; fins = 0; held = '0;
        for (int k = 0; k < 5; k++) begin
            WAIT = (k == 1);
            if (k == 1) held = RDATA0; else RDATA0 = $urandom;
            step();
            if (obs_state == INCRBW) cnt_cmd++;
            if (obs_ack[0]) acks++;
            if (obs_fin[0]) fins++;
            if (k == 1) chk("wait_data_stable", 64'(obs_data), 64'(held));
        end
        WAIT = 1'b0;
        chk("wait_incrbw_cycles", 64'(cnt_cmd), 64'd5);
        chk("wait_acks", 64'(acks), 64'd4);
        chk("wait_fins", 64'(fins), 64'd1);
        step();

        // RVALID low for one cycle mid-burst
        REQ = 2'b01; RWRITE = 2'b01; RLEN0 = 4'd3; RADDR0 = 26'h222;
        step();
        REQ = 2'b00;
        cnt_busy = 0; acks = 0; fins = 0;
        for (int k = 0; k < (BUSY_EN ? 6 : 4); k++) begin
            RVALID = (k == 1) ? 2'b10 : 2'b11;
            RDATA0 = $urandom;
            step();
            if (obs_state == BUSY) begin
                cnt_busy++;
                chk("busy_no_ack", 64'(obs_ack), 64'd0);
            end
            if (obs_ack[0]) acks++;
            if (obs_fin[0]) fins++;
        end
        RVALID = 2'b11;
        chk("busy_cycles", 64'(cnt_busy), BUSY_EN ? 64'd1 : 64'd0);
        chk("busy_acks", 64'(acks), 64'd4);
        chk("busy_fins", 64'(fins), 64'd1);
        step();

        // Both requesting from reset: grants alternate 0,1,0
        do_reset();
        arb_exp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
        REQ = 2'b11; RWRITE = 2'b00; RLEN0 = 4'd1; RLEN1 = 4'd1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("arb_gnt", 64'(obs_gnt), 64'(arb_exp[k]));
            chk("arb_state", 64'(obs_state), (arb_exp[k] == 2'b00) ? 64'(IDLE) : 64'(INCRBR));
            chk("arb_data", 64'(obs_data), 64'd0);
        end
        REQ = 2'b00;
        step();

        // Reset asserted during beat 2 of 4
        REQ = 2'b01; RWRITE = 2'b01; RLEN0 = 4'd3; RADDR0 = 26'h333;
        step();
        REQ = 2'b00;
        step();
        HRESETn = 1'b0;
        #1;
        chk("midrst_state", 64'(state), 64'(IDLE));
        chk("midrst_GNT", 64'(GNT), 64'd0);
        chk("midrst_FIN", 64'(FIN), 64'd0);
        chk("midrst_ACK", 64'(ACK), 64'd0);
        model_reset();
        @(posedge HCLK);
        #1;
        REQ = 2'b11; RWRITE = 2'b00; RLEN0 = 4'd0; RLEN1 = 4'd0;
        HRESETn = 1'b1;
        step();
        chk("midrst_regrant", 64'(GNT), 64'd1);
        REQ = 2'b00;
        step();
        step();

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            REQ    = 2'($urandom_range(0, 3));
            RWRITE = 2'($urandom_range(0, 3));
            RLEN0  = LEN_W'($urandom_range(0, 3));
            RLEN1  = LEN_W'($urandom_range(0, 3));
            RADDR0 = 26'($urandom);
            RADDR1 = 26'($urandom);
            RDATA0 = $urandom;
            RDATA1 = $urandom;
            RVALID = {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)};
            WAIT   = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
